// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: drives several packed BCD digits through one shared,
// registered BCD-to-7-segment decoder by time-multiplexing the common anodes.
// Each digit slot is a blanking gap (all anodes off, new nibble presented)
// followed by the anode-on period. Frames arrive over valid/ready into a
// one-deep pending buffer and are committed only at the frame boundary.
module display_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 2
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iValid,
  input  logic [4*DIGITS-1:0]   iDatos,
  output logic                  oReady,
  input  logic                  iLZS,
  output logic [3:0]            oBcd,
  output logic [DIGITS-1:0]     oAnodos
);

  localparam int CNT_MAX = (BLANK > PRESCALE) ? BLANK : PRESCALE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic                  full_q, full_d;
  logic                  ready_q, ready_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [DIGITS-1:0]     anod_q, anod_d;

  logic                  accept;
  logic                  boundary;
  logic                  commit;
  logic [IDX_W-1:0]      idx_next;

  // Select nibble i of a packed frame.
  function automatic logic [3:0] nibble_at(input logic [4*DIGITS-1:0] f,
                                           input logic [IDX_W-1:0]    i);
    nibble_at = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i == IDX_W'(k)) nibble_at = f[4*k +: 4];
    end
  endfunction

  // Digit i (i>0) is a leading zero when it and every higher digit are zero.
  function automatic logic is_leading_zero(input logic [4*DIGITS-1:0] f,
                                           input logic [IDX_W-1:0]    i);
    logic upper_zero;
    is_leading_zero = 1'b0;
    upper_zero      = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (f[4*k +: 4] != 4'h0) upper_zero = 1'b0;
      if ((i == IDX_W'(k)) && upper_zero) is_leading_zero = 1'b1;
    end
  endfunction

  // Next-state logic: frame handshake, slot sequencing and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    full_d  = full_q;
    bcd_d   = bcd_q;
    anod_d  = anod_q;

    accept   = iValid && ready_q;
    boundary = (state_q == S_SHOW) && (idx_q == IDX_LAST) && (cnt_q == SHOW_LAST);
    // Commit needs a frame already buffered, so a frame accepted on the
    // boundary cycle itself waits a full frame; accept and commit never overlap.
    commit   = boundary && full_q;
    idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    if (commit) begin
      disp_d = pend_q;
      full_d = 1'b0;
    end
    if (accept) begin
      pend_d = iDatos;
      full_d = 1'b1;
    end
    ready_d = ~full_d;

    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          anod_d  = '1;
          if (!(iLZS && is_leading_zero(disp_q, idx_q))) anod_d[idx_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = idx_next;
          anod_d  = '1;
          // On the boundary the next digit 0 comes from the frame being committed.
          bcd_d   = nibble_at(commit ? pend_q : disp_q, idx_next);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
        anod_d  = '1;
      end
    endcase
  end

  // State and output registers; reset forces blanked display immediately.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      bcd_q   <= 4'h0;
      anod_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      bcd_q   <= bcd_d;
      anod_q  <= anod_d;
    end
  end

  assign oReady  = ready_q;
  assign oBcd    = bcd_q;
  assign oAnodos = anod_q;

endmodule
